// File: rtl/wb_dma_rf_wb_slv.sv
// Wishbone slave front-end for the DMA register file.
// Turns host bus cycles into one-cycle register-file strobes and returns ack/err.
module wb_dma_rf_wb_slv #(
    parameter int unsigned CH_COUNT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_addr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [7:0]  wb_rf_adr,
    output logic [31:0] wb_rf_din,
    output logic        wb_rf_we,
    output logic        wb_rf_re,
    input  logic [31:0] wb_rf_dout
);

    typedef enum logic [2:0] {IDLE, WR, RD, RD2, DONE} state_t;

    state_t     state;
    logic       req;
    logic       valid;
    logic [4:0] blk;
    logic       unused_addr;

    assign req         = wb_cyc_i & wb_stb_i;
    assign blk         = wb_addr_i[9:5];
    assign valid       = (32'(blk) <= CH_COUNT) && (wb_sel_i == 4'hF) &&
                         (wb_addr_i[1:0] == 2'b00);
    assign unused_addr = ^wb_addr_i[31:10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wb_data_o <= '0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_rf_adr <= '0;
            wb_rf_din <= '0;
            wb_rf_we  <= 1'b0;
            wb_rf_re  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!valid) begin
                            wb_err_o <= 1'b1;
                            state    <= DONE;
                        end else if (wb_we_i) begin
                            wb_rf_adr <= wb_addr_i[9:2];
                            wb_rf_din <= wb_data_i;
                            wb_rf_we  <= 1'b1;
                            state     <= WR;
                        end else begin
                            wb_rf_adr <= wb_addr_i[9:2];
                            wb_rf_re  <= 1'b1;
                            state     <= RD;
                        end
                    end
                end
                WR: begin
                    // A write strobe already issued is not retracted on abort.
                    wb_rf_we <= 1'b0;
                    if (!wb_cyc_i) begin
                        state <= IDLE;
                    end else begin
                        wb_ack_o <= 1'b1;
                        state    <= DONE;
                    end
                end
                RD: begin
                    wb_rf_re <= 1'b0;
                    state    <= wb_cyc_i ? RD2 : IDLE;
                end
                RD2: begin
                    if (!wb_cyc_i) begin
                        state <= IDLE;
                    end else begin
                        wb_data_o <= wb_rf_dout;
                        wb_ack_o  <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Request is not sampled here, so a held stb is not served twice.
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dma_rf_wb_slv.sv
// Bench for wb_dma_rf_wb_slv: timeline model of each bus access checked every cycle,
// plus directed accesses with literal expectations.
module tb_wb_dma_rf_wb_slv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_addr_i, wb_data_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_data_o;
    logic        wb_ack_o, wb_err_o;
    logic [7:0]  wb_rf_adr;
    logic [31:0] wb_rf_din;
    logic        wb_rf_we, wb_rf_re;
    logic [31:0] wb_rf_dout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_dma_rf_wb_slv #(.CH_COUNT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_addr_i (wb_addr_i),
        .wb_sel_i  (wb_sel_i),
        .wb_data_i (wb_data_i),
        .wb_data_o (wb_data_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .wb_rf_adr (wb_rf_adr),
        .wb_rf_din (wb_rf_din),
        .wb_rf_we  (wb_rf_we),
        .wb_rf_re  (wb_rf_re),
        .wb_rf_dout(wb_rf_dout)
    );

    // Register-file environment: registered read data, counters for strobes/acks.
    logic [31:0] rf_mem [256];
    int we_cnt, ack_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) rf_mem[i] <= 32'h0;
            rf_mem[11] <= 32'hFFFF_FFFC;
            wb_rf_dout <= 32'h0;
            we_cnt     <= 0;
            ack_cnt    <= 0;
        end else begin
            if (wb_rf_re) wb_rf_dout <= rf_mem[wb_rf_adr];
            if (wb_rf_we) rf_mem[wb_rf_adr] <= wb_rf_din;
            if (wb_rf_we) we_cnt <= we_cnt + 1;
            if (wb_ack_o) ack_cnt <= ack_cnt + 1;
        end
    end

    // Model: each accepted access is a timeline of fixed offsets from its sampling edge.
    typedef enum logic [1:0] {K_NONE, K_WR, K_RD, K_ERR} kind_t;
    typedef struct {
        int          n;      // edge index since reset
        int          fa;     // first edge at which a new request may be sampled
        int          st;     // sampling edge of current access
        int          ak;     // edge at which its ack rises
        bit          cancel;
        kind_t       kind;
        bit          acc_wr;
        bit          we, re, ack, err;
        logic [7:0]  adr;
        logic [31:0] din;
    } model_t;

    function automatic model_t model_reset();
        model_t r;
        r.n = 0; r.fa = 0; r.st = -10; r.ak = -10; r.cancel = 1'b1; r.kind = K_NONE;
        r.acc_wr = 1'b0; r.we = 1'b0; r.re = 1'b0; r.ack = 1'b0; r.err = 1'b0;
        r.adr = 8'h0; r.din = 32'h0;
        return r;
    endfunction

    function automatic model_t step(model_t m, logic cyc, logic stb, logic we,
                                    logic [31:0] a, logic [3:0] s, logic [31:0] d);
        model_t r = m;
        bit ok;
        r.n = m.n + 1;
        r.acc_wr = 1'b0;
        if (r.kind != K_NONE && !r.cancel && r.n > r.st && r.n <= r.ak && !cyc) begin
            r.cancel = 1'b1;
            r.fa = r.n + 1;
        end
        if (r.n >= r.fa && cyc && stb) begin
            ok = (a[9:5] <= 5'd2) && (s == 4'hF) && (a[1:0] == 2'b00);
            r.st = r.n;
            r.cancel = 1'b0;
            if (!ok) begin
                r.kind = K_ERR; r.ak = -10; r.fa = r.n + 2;
            end else if (we) begin
                r.kind = K_WR; r.adr = a[9:2]; r.din = d; r.ak = r.n + 1; r.fa = r.n + 3;
                r.acc_wr = 1'b1;
            end else begin
                r.kind = K_RD; r.adr = a[9:2]; r.ak = r.n + 2; r.fa = r.n + 4;
            end
        end
        r.we  = (r.kind == K_WR)  && (r.n == r.st);
        r.re  = (r.kind == K_RD)  && (r.n == r.st);
        r.err = (r.kind == K_ERR) && (r.n == r.st);
        r.ack = !r.cancel && (r.n == r.ak);
        return r;
    endfunction

    model_t      m, nxt;
    logic [31:0] e_dout;
    logic [31:0] mmem [256];

    always_comb nxt = step(m, wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_data_i);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m      <= model_reset();
            e_dout <= 32'h0;
            for (int i = 0; i < 256; i++) mmem[i] <= 32'h0;
            mmem[11] <= 32'hFFFF_FFFC;
        end else begin
            m <= nxt;
            if (nxt.ack && nxt.kind == K_RD) e_dout <= mmem[nxt.adr];
            if (nxt.acc_wr) mmem[nxt.adr] <= nxt.din;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_we",   32'(wb_rf_we),  32'(m.we));
        chk("cyc_re",   32'(wb_rf_re),  32'(m.re));
        chk("cyc_ack",  32'(wb_ack_o),  32'(m.ack));
        chk("cyc_err",  32'(wb_err_o),  32'(m.err));
        chk("cyc_adr",  32'(wb_rf_adr), 32'(m.adr));
        chk("cyc_din",  wb_rf_din, m.din);
        chk("cyc_data", wb_data_o, e_dout);
    end

    task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w;
        wb_addr_i = a; wb_sel_i = s; wb_data_i = d;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o || wb_err_o) return;
        end
        checks++; errors++;
        $display("FAIL req_timeout: got no termination expected ack/err for addr %h", a);
    endtask

    task automatic drop();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge clk); #1;
    endtask

    int base;

    initial begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_addr_i = 32'h0; wb_sel_i = 4'h0; wb_data_i = 32'h0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_data", wb_data_o, 32'h0);
        @(posedge clk); #1;

        do_req(1'b1, 32'h20, 4'hF, 32'h41);
        drop();
        chk("wr_adr", 32'(wb_rf_adr), 32'h08);
        chk("wr_din", wb_rf_din, 32'h41);
        chk("wr_we_count", 32'(we_cnt), 32'd1);

        do_req(1'b0, 32'h2C, 4'hF, 32'h0);
        drop();
        chk("rd_data", wb_data_o, 32'hFFFF_FFFC);

        do_req(1'b0, 32'h60, 4'hF, 32'h0);
        drop();
        chk("err_blk_adr", 32'(wb_rf_adr), 32'h0B);
        do_req(1'b1, 32'h20, 4'h3, 32'h55);
        drop();
        chk("err_sel_adr", 32'(wb_rf_adr), 32'h0B);
        do_req(1'b1, 32'h42, 4'hF, 32'h66);
        drop();
        chk("err_align_we", 32'(we_cnt), 32'd1);

        do_req(1'b1, 32'h44, 4'hF, 32'hA5A5_0F0F);
        drop();
        do_req(1'b0, 32'h44, 4'hF, 32'h0);
        drop();
        chk("readback", wb_data_o, 32'hA5A5_0F0F);

        // Back-to-back: stb held through the first ack into a second write.
        base = we_cnt;
        do_req(1'b1, 32'h30, 4'hF, 32'h1111_2222);
        do_req(1'b1, 32'h34, 4'hF, 32'h3333_4444);
        drop();
        chk("b2b_we_count", 32'(we_cnt - base), 32'd2);
        chk("b2b_din", wb_rf_din, 32'h3333_4444);

        // Abort a read in RD.
        base = ack_cnt;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_addr_i = 32'h2C; wb_sel_i = 4'hF;
        @(posedge clk); #1;
        chk("abort_re", 32'(wb_rf_re), 32'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("abort_no_ack", 32'(ack_cnt - base), 32'd0);
        do_req(1'b0, 32'h30, 4'hF, 32'h0);
        drop();
        chk("after_abort_data", wb_data_o, 32'h1111_2222);

        // Reset while the read is in RD2.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_addr_i = 32'h44; wb_sel_i = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_ack",  32'(wb_ack_o),  32'd0);
        chk("rst_err",  32'(wb_err_o),  32'd0);
        chk("rst_re",   32'(wb_rf_re),  32'd0);
        chk("rst_we",   32'(wb_rf_we),  32'd0);
        chk("rst_adr",  32'(wb_rf_adr), 32'd0);
        chk("rst_din",  wb_rf_din, 32'd0);
        chk("rst_data", wb_data_o, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("rst_no_ack", 32'(ack_cnt), 32'd0);

        do_req(1'b0, 32'h2C, 4'hF, 32'h0);
        drop();
        chk("post_rst_read", wb_data_o, 32'hFFFF_FFFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
